// File: rtl/scs8hd_edfx_bank_wr_arb_if.sv
// Bundle of requester and bank-side signals for the bank write arbiter.
//   master : requester/bank side (drives REQ_*, HOLD; observes READY and bank pins)
//   slave  : the arbiter itself
// Signals:
//   REQ_VALID/REQ_LOCK [NREQ]     per-requester write pending / keep exclusive grant
//   REQ_ADDR [NREQ*AW]            word address, slice i = [i*AW +: AW]
//   REQ_DATA [NREQ*DW]            write data,   slice i = [i*DW +: DW]
//   REQ_READY [NREQ]              one-hot or zero grant (combinational)
//   HOLD                          freeze arbitration
//   BANK_D [DW], BANK_DE [2**AW]  registered data and one-hot word enable to the bank
//   GNT_ID, GNT_VALID             registered owner of the current bank write
interface scs8hd_edfx_bank_wr_arb_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 3
);
    localparam int IDW   = $clog2(NREQ);
    localparam int DEPTH = 2 ** AW;

    logic [NREQ-1:0]    REQ_VALID;
    logic [NREQ-1:0]    REQ_LOCK;
    logic [NREQ*AW-1:0] REQ_ADDR;
    logic [NREQ*DW-1:0] REQ_DATA;
    logic [NREQ-1:0]    REQ_READY;
    logic               HOLD;
    logic [DW-1:0]      BANK_D;
    logic [DEPTH-1:0]   BANK_DE;
    logic [IDW-1:0]     GNT_ID;
    logic               GNT_VALID;

    modport master (
        output REQ_VALID, REQ_LOCK, REQ_ADDR, REQ_DATA, HOLD,
        input  REQ_READY, BANK_D, BANK_DE, GNT_ID, GNT_VALID
    );

    modport slave (
        input  REQ_VALID, REQ_LOCK, REQ_ADDR, REQ_DATA, HOLD,
        output REQ_READY, BANK_D, BANK_DE, GNT_ID, GNT_VALID
    );
endinterface

// File: rtl/scs8hd_edfx_bank_wr_arb.sv
// Round-robin write arbiter for a register bank built from enable flops.
// One requester per cycle gets REQ_READY; on handshake its data/address are
// registered onto BANK_D / BANK_DE (one-hot word enable) for exactly one cycle.
// A requester transferring with REQ_LOCK=1 keeps exclusive grant until it
// transfers with REQ_LOCK=0.
// Ports:
//   CLK    rising-edge clock shared with the bank flops
//   RESET  synchronous active-high reset
//   bus    arbiter side of scs8hd_edfx_bank_wr_arb_if
module scs8hd_edfx_bank_wr_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 3
) (
    input  logic                          CLK,
    input  logic                          RESET,
    scs8hd_edfx_bank_wr_arb_if.slave      bus
);
    localparam int IDW   = $clog2(NREQ);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDW-1:0]   own_r;
    logic [IDW-1:0]   own_nxt_s;
    logic [IDW-1:0]   ptr_r;
    logic [IDW-1:0]   win_s;
    logic [IDW-1:0]   cand_s;
    logic [NREQ-1:0]  ready_s;
    logic             found_s;
    logic             xfer_s;
    logic [AW-1:0]    addr_s [NREQ];
    logic [DW-1:0]    data_s [NREQ];
    logic [DW-1:0]    bank_d_r;
    logic [DEPTH-1:0] bank_de_r;
    logic [IDW-1:0]   gnt_id_r;
    logic             gnt_valid_r;

    // (base + k) mod NREQ without relying on NREQ being a power of two
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned k);
        int unsigned sum;
        sum = 32'(base) + k;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end else begin
            sum = sum;
        end
        return sum[IDW-1:0];
    endfunction

    // Unpack the flat address/data buses into per-requester slices
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_s[i] = bus.REQ_ADDR[i*AW +: AW];
            data_s[i] = bus.REQ_DATA[i*DW +: DW];
        end
    end

    // Grant selection: rotating search from PTR when idle, owner only when locked
    always_comb begin
        ready_s = {NREQ{1'b0}};
        win_s   = {IDW{1'b0}};
        cand_s  = {IDW{1'b0}};
        found_s = 1'b0;
        if (RESET || bus.HOLD) begin
            ready_s = {NREQ{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    for (int k = 0; k < NREQ; k++) begin
                        cand_s = wrap_add(ptr_r, k);
                        if (!found_s && bus.REQ_VALID[cand_s]) begin
                            ready_s[cand_s] = 1'b1;
                            win_s           = cand_s;
                            found_s         = 1'b1;
                        end else begin
                            found_s = found_s;
                        end
                    end
                end
                ST_LOCKED: begin
                    ready_s[own_r] = bus.REQ_VALID[own_r];
                    win_s          = own_r;
                    found_s        = bus.REQ_VALID[own_r];
                end
                default: begin
                    ready_s = {NREQ{1'b0}};
                end
            endcase
        end
    end

    assign xfer_s = |(bus.REQ_VALID & ready_s);

    // Next-state: lock bit of the transferring requester decides the following state
    always_comb begin
        state_nxt_s = state_r;
        own_nxt_s   = own_r;
        if (xfer_s) begin
            if (bus.REQ_LOCK[win_s]) begin
                state_nxt_s = ST_LOCKED;
                own_nxt_s   = win_s;
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            own_r   <= {IDW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            own_r   <= own_nxt_s;
        end
    end

    // Bank write datapath and rotation pointer; BANK_D/GNT_ID hold between writes
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bank_d_r    <= {DW{1'b0}};
            bank_de_r   <= {DEPTH{1'b0}};
            gnt_id_r    <= {IDW{1'b0}};
            gnt_valid_r <= 1'b0;
            ptr_r       <= {IDW{1'b0}};
        end else if (xfer_s) begin
            bank_d_r    <= data_s[win_s];
            bank_de_r   <= {{(DEPTH-1){1'b0}}, 1'b1} << addr_s[win_s];
            gnt_id_r    <= win_s;
            gnt_valid_r <= 1'b1;
            ptr_r       <= wrap_add(win_s, 32'd1);
        end else begin
            bank_de_r   <= {DEPTH{1'b0}};
            gnt_valid_r <= 1'b0;
        end
    end

    assign bus.REQ_READY = ready_s;
    assign bus.BANK_D    = bank_d_r;
    assign bus.BANK_DE   = bank_de_r;
    assign bus.GNT_ID    = gnt_id_r;
    assign bus.GNT_VALID = gnt_valid_r;
endmodule

// File: tb/tb_scs8hd_edfx_bank_wr_arb.sv
module tb_scs8hd_edfx_bank_wr_arb;
    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int IDW   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scs8hd_edfx_bank_wr_arb_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus();

    scs8hd_edfx_bank_wr_arb #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int               m_ptr;
    bit               m_locked;
    int               m_own;
    logic [DW-1:0]    exp_d;
    logic [DEPTH-1:0] exp_de;
    logic [IDW-1:0]   exp_id;
    logic             exp_gv;
    int               last_w;

    // Expected READY from the arbitration rules
    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] r;
        int idx;
        r = '0;
        if (rst || bus.HOLD) return r;
        if (m_locked) begin
            if (bus.REQ_VALID[m_own]) r[m_own] = 1'b1;
            return r;
        end
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (bus.REQ_VALID[idx]) begin
                r[idx] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    // Advance one clock and update the model; no checking here
    task automatic tick();
        logic [NREQ-1:0] r;
        int w;
        r = model_ready();
        w = -1;
        for (int i = 0; i < NREQ; i++) if (r[i]) w = i;
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_locked = 0; m_own = 0;
            exp_d = '0; exp_de = '0; exp_id = '0; exp_gv = 1'b0;
            w = -1;
        end else if (w >= 0) begin
            exp_d    = bus.REQ_DATA[w*DW +: DW];
            exp_de   = DEPTH'(1) << bus.REQ_ADDR[w*AW +: AW];
            exp_id   = IDW'(w);
            exp_gv   = 1'b1;
            m_ptr    = (w + 1) % NREQ;
            m_locked = bus.REQ_LOCK[w];
            m_own    = w;
        end else begin
            exp_de = '0;
            exp_gv = 1'b0;
        end
        last_w = w;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit v, input bit l, input int a, input int d);
        bus.REQ_VALID[i]          = v;
        bus.REQ_LOCK[i]           = l;
        bus.REQ_ADDR[i*AW +: AW]  = a[AW-1:0];
        bus.REQ_DATA[i*DW +: DW]  = d[DW-1:0];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.HOLD = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, i, 8'hA0 + i);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (bus.REQ_READY !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_ready: got %b want 0000", bus.REQ_READY);
            end
            tick();
            n_checks++;
            if ({bus.BANK_DE, bus.GNT_VALID, bus.BANK_D, bus.GNT_ID} !== {8'h00, 1'b0, 8'h00, 2'd0}) begin
                n_fail++;
                $display("FAIL reset_outputs: de=%h gv=%b d=%h id=%0d want all zero",
                         bus.BANK_DE, bus.GNT_VALID, bus.BANK_D, bus.GNT_ID);
            end
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.REQ_READY !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 0001", bus.REQ_READY);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] er;
        for (int c = 0; c < 5; c++) begin
            er = model_ready();
            n_checks++;
            if (bus.REQ_READY !== er || er !== 4'(1 << (c % 4))) begin
                n_fail++;
                $display("FAIL rr_ready[%0d]: got %b model %b", c, bus.REQ_READY, er);
            end
            tick();
            n_checks++;
            if ({bus.GNT_ID, bus.BANK_DE, bus.BANK_D, bus.GNT_VALID} !==
                {2'(c % 4), 8'(1 << (c % 4)), 8'(8'hA0 + (c % 4)), 1'b1}) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: id=%0d de=%h d=%h gv=%b want id=%0d",
                         c, bus.GNT_ID, bus.BANK_DE, bus.BANK_D, bus.GNT_VALID, c % 4);
            end
            #1;
        end
    endtask

    task automatic test_lock();
        logic [NREQ-1:0] want_r [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
        int              want_id [5] = '{1, 1, 1, 1, 2};
        bus.REQ_LOCK[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) bus.REQ_LOCK[1] = 1'b0;
            #1;
            n_checks++;
            if (bus.REQ_READY !== want_r[c] || model_ready() !== want_r[c]) begin
                n_fail++;
                $display("FAIL lock_ready[%0d]: got %b want %b", c, bus.REQ_READY, want_r[c]);
            end
            tick();
            n_checks++;
            if (bus.GNT_ID !== 2'(want_id[c]) || bus.GNT_VALID !== 1'b1 || bus.BANK_DE !== exp_de) begin
                n_fail++;
                $display("FAIL lock_grant[%0d]: id=%0d gv=%b de=%h want id=%0d de=%h",
                         c, bus.GNT_ID, bus.GNT_VALID, bus.BANK_DE, want_id[c], exp_de);
            end
        end
    endtask

    task automatic test_hold();
        #1;
        tick();
        bus.HOLD = 1'b1;
        #1;
        n_checks++;
        if (bus.BANK_DE !== 8'h08 || bus.GNT_VALID !== 1'b1 || bus.GNT_ID !== 2'd3) begin
            n_fail++;
            $display("FAIL hold_pulse: de=%h gv=%b id=%0d want de=08 gv=1 id=3",
                     bus.BANK_DE, bus.GNT_VALID, bus.GNT_ID);
        end
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (bus.REQ_READY !== 4'b0000) begin
                n_fail++;
                $display("FAIL hold_ready[%0d]: got %b want 0000", c, bus.REQ_READY);
            end
            tick();
            #1;
            n_checks++;
            if (bus.BANK_DE !== 8'h00 || bus.GNT_VALID !== 1'b0 || bus.GNT_ID !== 2'd3) begin
                n_fail++;
                $display("FAIL hold_idle[%0d]: de=%h gv=%b id=%0d want de=00 gv=0 id=3",
                         c, bus.BANK_DE, bus.GNT_VALID, bus.GNT_ID);
            end
        end
        bus.HOLD = 1'b0;
        #1;
        n_checks++;
        if (bus.REQ_READY !== 4'b0001) begin
            n_fail++;
            $display("FAIL hold_release_ready: got %b want 0001", bus.REQ_READY);
        end
    endtask

    task automatic test_reset_inflight();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 4, 8'h50 + i);
        tick();
        bus.REQ_LOCK = 4'b1111;
        tick();
        #1;
        n_checks++;
        if (bus.BANK_DE !== 8'h10 || bus.GNT_ID !== 2'd1) begin
            n_fail++;
            $display("FAIL inflight_de: de=%h id=%0d want de=10 id=1", bus.BANK_DE, bus.GNT_ID);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.REQ_READY !== 4'b0000) begin
            n_fail++;
            $display("FAIL inflight_rst_ready: got %b want 0000", bus.REQ_READY);
        end
        tick();
        n_checks++;
        if ({bus.BANK_DE, bus.GNT_VALID, bus.GNT_ID, bus.BANK_D} !== {8'h00, 1'b0, 2'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL inflight_rst_out: de=%h gv=%b id=%0d d=%h want zeros",
                     bus.BANK_DE, bus.GNT_VALID, bus.GNT_ID, bus.BANK_D);
        end
        rst = 1'b0;
        bus.REQ_LOCK = 4'b0000;
        #1;
        n_checks++;
        if (bus.REQ_READY !== 4'b0001) begin
            n_fail++;
            $display("FAIL inflight_post_ready: got %b want 0001", bus.REQ_READY);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] want_d [3] = '{8'h3C, 8'hC3, 8'hC3};
        logic [DEPTH-1:0] want_de [3] = '{8'h20, 8'h20, 8'h00};
        bus.REQ_VALID = '0;
        bus.REQ_LOCK  = '0;
        set_req(2, 1'b1, 1'b0, 5, 8'h3C);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) set_req(2, 1'b1, 1'b0, 5, 8'hC3);
            if (c == 2) set_req(2, 1'b0, 1'b0, 5, 8'hC3);
            #1;
            n_checks++;
            if (bus.REQ_READY !== ((c < 2) ? 4'b0100 : 4'b0000)) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %b", c, bus.REQ_READY);
            end
            tick();
            n_checks++;
            if (bus.BANK_DE !== want_de[c] || bus.BANK_D !== want_d[c] ||
                bus.GNT_VALID !== (c < 2) || bus.GNT_ID !== 2'd2) begin
                n_fail++;
                $display("FAIL b2b_out[%0d]: de=%h d=%h gv=%b id=%0d want de=%h d=%h",
                         c, bus.BANK_DE, bus.BANK_D, bus.GNT_VALID, bus.GNT_ID, want_de[c], want_d[c]);
            end
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] er;
        bus.REQ_VALID = '0;
        last_w = -1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(bus.REQ_VALID[i] && last_w != i)) begin
                    set_req(i, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                            int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)));
                end
            end
            bus.HOLD = ($urandom_range(0, 7) == 0);
            #1;
            er = model_ready();
            n_checks++;
            if (bus.REQ_READY !== er) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b model %b", c, bus.REQ_READY, er);
            end
            tick();
            n_checks++;
            if ({bus.BANK_DE, bus.BANK_D, bus.GNT_ID, bus.GNT_VALID} !== {exp_de, exp_d, exp_id, exp_gv}) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: de=%h d=%h id=%0d gv=%b model de=%h d=%h id=%0d gv=%b",
                         c, bus.BANK_DE, bus.BANK_D, bus.GNT_ID, bus.GNT_VALID,
                         exp_de, exp_d, exp_id, exp_gv);
            end
        end
        bus.HOLD = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.REQ_VALID = '0;
        bus.REQ_LOCK  = '0;
        bus.REQ_ADDR  = '0;
        bus.REQ_DATA  = '0;
        bus.HOLD      = 1'b0;
        m_ptr = 0; m_locked = 0; m_own = 0;
        exp_d = '0; exp_de = '0; exp_id = '0; exp_gv = 1'b0;
        last_w = -1;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_lock();
        test_hold();
        test_reset_inflight();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
